mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 16: byte address width; equals TestRam address width.
REQ-002 Parameter DATA_WIDTH, default 8: byte width; equals TestRam data width.
REQ-003 Parameter TIMEOUT, default 15: max cycles waited for ram_data_ready per byte.
REQ-004 Port clk  in  1  sole clock; all logic on posedge.
REQ-005 Port rst_n  in  1  reset, synchronous, active-low.
REQ-006 Port cpu_req  in  1  access request, sampled when busy=0.
REQ-007 Port cpu_we  in  1  1=write, 0=read; sampled with cpu_req.
REQ-008 Port cpu_wide  in  1  1=16-bit (two-byte) access, 0=single byte.
REQ-009 Port cpu_addr  in  ADDR_WIDTH  byte address of low byte.
REQ-010 Port cpu_wdata  in  2*DATA_WIDTH  write data; low byte [DATA_WIDTH-1:0].
REQ-011 Port cpu_rdata  out  2*DATA_WIDTH  read data, valid when cpu_done=1.
REQ-012 Port cpu_done  out  1  one-cycle completion pulse.
REQ-013 Port cpu_err  out  1  one-cycle timeout pulse, replaces cpu_done.
REQ-014 Port busy  out  1  1 while an access is in flight.
REQ-015 Ports ram_req_rdwr, ram_we (out 1), ram_addr (out ADDR_WIDTH), ram_data_in (out DATA_WIDTH): drive TestRam req_rdwr/we/addr/data_in.
REQ-016 Ports ram_data_out (in DATA_WIDTH), ram_data_ready (in 1): from TestRam data_out/data_ready.

Function
REQ-017 States SHALL be IDLE, LO_ACC, GAP, HI_ACC, DONE, ERR.
REQ-018 IDLE/DONE/ERR with cpu_req=1: latch we, wide, addr, wdata; clear rdata; go LO_ACC; otherwise go/stay IDLE.
REQ-019 LO_ACC/HI_ACC: ram_req_rdwr=1, ram_addr/ram_we/ram_data_in held constant from state entry until exit.
REQ-020 ram_we=1 only in LO_ACC/HI_ACC of a write; never while ram_req_rdwr=0.
REQ-021 LO_ACC with ram_data_ready=1: read captures ram_data_out into rdata[DATA_WIDTH-1:0]; next state GAP if wide else DONE.
REQ-022 GAP: ram_req_rdwr=0 for exactly one cycle (clears stale data_ready), then HI_ACC.
REQ-023 HI_ACC with ram_data_ready=1: read captures into rdata upper byte; next DONE.
REQ-024 HI_ACC address = latched addr + 1 modulo 2^ADDR_WIDTH (all-ones wraps to 0).
REQ-025 Narrow read: cpu_rdata upper byte = 0.
REQ-026 Wait counter resets on entry to LO_ACC/HI_ACC; reaching TIMEOUT cycles without ram_data_ready -> ERR, ram_req_rdwr dropped.
REQ-027 DONE: cpu_done=1, busy=0, cpu_rdata valid one cycle. ERR: cpu_err=1, busy=0, cpu_rdata=0.
REQ-028 busy=1 in LO_ACC, GAP, HI_ACC; cpu_req there ignored, not queued.
REQ-029 Back-to-back: cpu_req in DONE accepted; DONE's ram_req_rdwr=0 provides the mandatory gap.
REQ-030 ram_data_ready in IDLE/GAP/DONE/ERR ignored.
REQ-031 All outputs registered; no combinational input-to-output path.

Reset
REQ-032 rst_n=0 at posedge: state IDLE; all outputs, counter, latches 0 on next edge, including mid-access (RAM write in progress abandoned).
REQ-033 cpu_req ignored on any cycle rst_n=0.

Structure
REQ-034 ADDR/DATA widths come from test_ram_defines include; state encodings go in a new shared mem_access_ctrl_defines include.
REQ-035 No sub-module; benches instantiate mem_access_ctrl beside TestRam.

Verification
REQ-036 Narrow write 0x5A to 0x0010, then narrow read 0x0010 -> cpu_done, cpu_rdata=0x005A, ram_we never high with ram_req_rdwr low.
REQ-037 Wide write 0xBEEF to 0x0020, wide read -> mem[0x20]=0xEF, mem[0x21]=0xBE, rdata=0xBEEF, one-cycle GAP observed.
REQ-038 Wide read at 0xFFFF -> low byte from 0xFFFF, high byte from 0x0000.
REQ-039 ram_data_ready tied 0 -> cpu_err after TIMEOUT=15 wait cycles, busy 0, no cpu_done.
REQ-040 rst_n low during HI_ACC -> next edge all outputs 0, state IDLE; later read completes normally.
REQ-041 cpu_req held high continuously with TestRam -> reads issue back-to-back, each byte ram_req_rdwr separated by >=1 low cycle.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared TestRam widths, controller state encoding and state-class helpers
// for the CPU-to-TestRam byte/halfword access controller.
package mem_access_ctrl_pkg;

    localparam int TRAM_ADDR_WIDTH = 16;
    localparam int TRAM_DATA_WIDTH = 8;
    localparam int DEFAULT_TIMEOUT = 15;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LO_ACC = 3'd1,
        GAP    = 3'd2,
        HI_ACC = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    function automatic logic is_ram_phase(input state_t s);
        return (s == LO_ACC) || (s == HI_ACC);
    endfunction

    function automatic logic is_busy(input state_t s);
        return (s == LO_ACC) || (s == GAP) || (s == HI_ACC);
    endfunction

    function automatic logic accepts_req(input state_t s);
        return (s == IDLE) || (s == DONE) || (s == ERR);
    endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// Splits 8/16-bit CPU accesses into one or two TestRam byte transactions,
// with a per-byte data_ready timeout and fully registered outputs.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = TRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = TRAM_DATA_WIDTH,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic                    cpu_wide,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [2*DATA_WIDTH-1:0] cpu_wdata,
    output logic [2*DATA_WIDTH-1:0] cpu_rdata,
    output logic                    cpu_done,
    output logic                    cpu_err,
    output logic                    busy,
    output logic                    ram_req_rdwr,
    output logic                    ram_we,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_data_in,
    input  logic [DATA_WIDTH-1:0]   ram_data_out,
    input  logic                    ram_data_ready
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t state, next_state;

    logic                    we_q, we_d;
    logic                    wide_q, wide_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [2*DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [2*DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    req_d, hi_d, ram_we_d, busy_d, done_d, err_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_d;
    logic [DATA_WIDTH-1:0]   ram_din_d;
    logic [2*DATA_WIDTH-1:0] cpu_rdata_d;

    logic timed_out;
    assign timed_out = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERR: next_state = cpu_req ? LO_ACC : IDLE;
            LO_ACC: begin
                if (ram_data_ready)  next_state = wide_q ? GAP : DONE;
                else if (timed_out)  next_state = ERR;
            end
            GAP:    next_state = HI_ACC;
            HI_ACC: begin
                if (ram_data_ready)  next_state = DONE;
                else if (timed_out)  next_state = ERR;
            end
            default: next_state = IDLE;
        endcase
    end

    // Request latches, read capture and the per-byte wait counter.
    always_comb begin
        we_d    = we_q;
        wide_d  = wide_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        if (accepts_req(state) && cpu_req) begin
            we_d    = cpu_we;
            wide_d  = cpu_wide;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
            rdata_d = '0;
        end else if (is_ram_phase(state)) begin
            if (ram_data_ready) begin
                if (!we_q) begin
                    if (state == HI_ACC) rdata_d[2*DATA_WIDTH-1:DATA_WIDTH] = ram_data_out;
                    else                 rdata_d[DATA_WIDTH-1:0]            = ram_data_out;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        if (next_state != state) cnt_d = '0;
    end

    // Outputs are computed from the upcoming state so every port is a flop
    // that is stable for the whole cycle of the state it belongs to.
    always_comb begin
        req_d       = is_ram_phase(next_state);
        hi_d        = (next_state == HI_ACC);
        ram_addr_d  = '0;
        ram_din_d   = '0;
        if (req_d) begin
            ram_addr_d = hi_d ? addr_d + ADDR_WIDTH'(1) : addr_d;
            if (we_d) ram_din_d = hi_d ? wdata_d[2*DATA_WIDTH-1:DATA_WIDTH] : wdata_d[DATA_WIDTH-1:0];
        end
        ram_we_d    = req_d & we_d;
        busy_d      = is_busy(next_state);
        done_d      = (next_state == DONE);
        err_d       = (next_state == ERR);
        cpu_rdata_d = done_d ? rdata_d : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q         <= 1'b0;
            wide_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            cnt_q        <= '0;
            ram_req_rdwr <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_data_in  <= '0;
            busy         <= 1'b0;
            cpu_done     <= 1'b0;
            cpu_err      <= 1'b0;
            cpu_rdata    <= '0;
        end else begin
            we_q         <= we_d;
            wide_q       <= wide_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            cnt_q        <= cnt_d;
            ram_req_rdwr <= req_d;
            ram_we       <= ram_we_d;
            ram_addr     <= ram_addr_d;
            ram_data_in  <= ram_din_d;
            busy         <= busy_d;
            cpu_done     <= done_d;
            cpu_err      <= err_d;
            cpu_rdata    <= cpu_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a TestRam-like responder plus a
// transaction-level model (shadow memory + expectation queue) checked every cycle.
module tb_mem_access_ctrl;

    localparam int TIMEOUT = 15;
    localparam int RAM_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic        cpu_wide = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic [15:0] cpu_rdata;
    logic        cpu_done, cpu_err, busy;
    logic        ram_req_rdwr, ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_data_in;
    logic [7:0]  ram_data_out = '0;
    logic        ram_data_ready = 1'b0;

    mem_access_ctrl #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(8),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_wide(cpu_wide),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_err(cpu_err), .busy(busy),
        .ram_req_rdwr(ram_req_rdwr), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out), .ram_data_ready(ram_data_ready)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // TestRam stand-in: data_ready rises RAM_LAT+1 cycles into a request and
    // stays up until req_rdwr drops.
    logic [7:0] ram_mem [0:65535];
    int         ram_lat = 0;
    bit         ram_en = 1'b1;

    always @(posedge clk) begin
        if (!ram_req_rdwr) begin
            ram_data_ready <= 1'b0;
            ram_lat        <= 0;
        end else if (!ram_data_ready && ram_en) begin
            if (ram_lat >= RAM_LAT) begin
                if (ram_we) ram_mem[ram_addr] = ram_data_in;
                else        ram_data_out <= ram_mem[ram_addr];
                ram_data_ready <= 1'b1;
                ram_lat        <= 0;
            end else begin
                ram_lat <= ram_lat + 1;
            end
        end
    end

    typedef struct {
        bit          err;
        bit          we;
        bit          wide;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } exp_t;

    logic [7:0] shadow [0:65535];
    exp_t       exp_q[$];
    int         accept_cnt = 0;

    // Acceptance: a request sampled while the controller is not busy.
    always @(posedge clk) begin : accept_mon
        exp_t e;
        if (rst_n === 1'b1 && cpu_req === 1'b1 && busy === 1'b0) begin
            e.err   = !ram_en;
            e.we    = cpu_we;
            e.wide  = cpu_wide;
            e.addr  = cpu_addr;
            e.wdata = cpu_wdata;
            e.rdata = '0;
            if (!e.err) begin
                if (cpu_we) begin
                    shadow[cpu_addr] = cpu_wdata[7:0];
                    if (cpu_wide) shadow[cpu_addr + 16'd1] = cpu_wdata[15:8];
                end else begin
                    e.rdata[7:0] = shadow[cpu_addr];
                    if (cpu_wide) e.rdata[15:8] = shadow[cpu_addr + 16'd1];
                end
            end
            exp_q.push_back(e);
            accept_cnt++;
        end
    end

    int          nbytes = 0;
    int          run_len = 0;
    int          low_cnt = 99;
    int          min_low = 99;
    int          last_gap = 0;
    int          last_run = 0;
    int          completions = 0;
    bit          prev_req = 1'b0;
    logic [15:0] last_rdata = '0;
    bit          last_err = 1'b0;

    always @(negedge clk) begin : compare
        exp_t        e;
        logic [15:0] exp_addr;
        if (rst_n === 1'b1) begin
            check("we_without_req", 32'(ram_we & ~ram_req_rdwr), 32'd0);
            check("done_err_excl", 32'(cpu_done & cpu_err), 32'd0);
            check("busy", 32'(busy), 32'(exp_q.size() != 0 && !(cpu_done || cpu_err)));
            if (!busy) check("req_when_idle", 32'(ram_req_rdwr), 32'd0);
            if (ram_req_rdwr) begin
                if (!prev_req) begin
                    if (nbytes == 1) check("gap_len", 32'(low_cnt), 32'd1);
                    last_gap = low_cnt;
                    if (low_cnt < min_low) min_low = low_cnt;
                    nbytes++;
                    run_len = 0;
                end
                run_len++;
                low_cnt = 0;
                if (exp_q.size() == 0) begin
                    check("req_without_access", 32'd1, 32'd0);
                end else begin
                    e = exp_q[0];
                    exp_addr = e.addr + 16'(nbytes - 1);
                    check("ram_addr", 32'(ram_addr), 32'(exp_addr));
                    check("ram_we", 32'(ram_we), 32'(e.we));
                    if (e.we)
                        check("ram_data_in", 32'(ram_data_in),
                              32'((nbytes == 1) ? e.wdata[7:0] : e.wdata[15:8]));
                end
            end else begin
                low_cnt++;
            end
            prev_req = ram_req_rdwr;
            if (cpu_done || cpu_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("completion_is_err", 32'(cpu_err), 32'(e.err));
                    check("cpu_rdata", 32'(cpu_rdata), 32'(e.rdata));
                    check("byte_count", 32'(nbytes), 32'((e.err || !e.wide) ? 1 : 2));
                    if (e.err) check("timeout_len", 32'(run_len), 32'(TIMEOUT));
                    else       check("run_within_timeout", 32'(run_len <= TIMEOUT), 32'd1);
                    last_rdata = cpu_rdata;
                    last_err   = cpu_err;
                    last_run   = run_len;
                    completions++;
                end
                nbytes = 0;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(cpu_done), 32'd0);
        check({tag, "_err"}, 32'(cpu_err), 32'd0);
        check({tag, "_rdata"}, 32'(cpu_rdata), 32'd0);
        check({tag, "_req"}, 32'(ram_req_rdwr), 32'd0);
        check({tag, "_we"}, 32'(ram_we), 32'd0);
        check({tag, "_addr"}, 32'(ram_addr), 32'd0);
        check({tag, "_din"}, 32'(ram_data_in), 32'd0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(posedge clk); #2;
        end
        check("access_completes", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic issue(input bit we, input bit wide, input logic [15:0] addr, input logic [15:0] wdata);
        int n0;
        n0        = accept_cnt;
        cpu_we    = we;
        cpu_wide  = wide;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_req   = 1'b1;
        for (int i = 0; i < 20 && accept_cnt == n0; i++) begin
            @(posedge clk); #2;
        end
        cpu_req = 1'b0;
        check("request_accepted", 32'(accept_cnt != n0), 32'd1);
    endtask

    task automatic do_access(input bit we, input bit wide, input logic [15:0] addr, input logic [15:0] wdata);
        issue(we, wide, addr, wdata);
        wait_idle();
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n0;
        for (int i = 0; i < 65536; i++) begin
            ram_mem[i] = 8'h00;
            shadow[i]  = 8'h00;
        end
        ram_mem[16'hFFFF] = 8'h12; shadow[16'hFFFF] = 8'h12;
        ram_mem[16'h0000] = 8'h34; shadow[16'h0000] = 8'h34;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        #1;
        rst_n = 1'b1;

        do_access(1'b1, 1'b0, 16'h0010, 16'h005A);
        check("mem_0010", 32'(ram_mem[16'h0010]), 32'h5A);
        do_access(1'b0, 1'b0, 16'h0010, 16'h0000);
        check("narrow_read_rdata", 32'(last_rdata), 32'h005A);

        do_access(1'b1, 1'b1, 16'h0020, 16'hBEEF);
        check("mem_0020", 32'(ram_mem[16'h0020]), 32'hEF);
        check("mem_0021", 32'(ram_mem[16'h0021]), 32'hBE);
        do_access(1'b0, 1'b1, 16'h0020, 16'h0000);
        check("wide_read_rdata", 32'(last_rdata), 32'hBEEF);
        check("wide_read_gap", 32'(last_gap), 32'd1);

        do_access(1'b0, 1'b1, 16'hFFFF, 16'h0000);
        check("wrap_read_rdata", 32'(last_rdata), 32'h3412);
        do_access(1'b1, 1'b1, 16'hFFFF, 16'hA55A);
        check("wrap_write_hi", 32'(ram_mem[16'h0000]), 32'hA5);
        do_access(1'b0, 1'b0, 16'h0000, 16'h0000);
        check("wrap_readback", 32'(last_rdata), 32'h00A5);

        ram_en = 1'b0;
        n0 = completions;
        do_access(1'b0, 1'b0, 16'h0040, 16'h0000);
        check("timeout_err", 32'(last_err), 32'd1);
        check("timeout_cycles", 32'(last_run), 32'd15);
        check("timeout_one_completion", 32'(completions - n0), 32'd1);
        check("timeout_busy", 32'(busy), 32'd0);
        ram_en = 1'b1;

        issue(1'b0, 1'b1, 16'h0030, 16'h0000);
        for (int i = 0; i < 40 && !(ram_req_rdwr && ram_addr == 16'h0031); i++) begin
            @(posedge clk); #2;
        end
        check("reached_hi_acc", 32'(ram_req_rdwr && ram_addr == 16'h0031), 32'd1);
        rst_n   = 1'b0;
        cpu_req = 1'b1;
        @(posedge clk); #1;
        check_all_zero("midreset");
        exp_q.delete();
        nbytes   = 0;
        prev_req = 1'b0;
        low_cnt  = 99;
        rst_n    = 1'b1;
        cpu_req  = 1'b0;
        @(posedge clk); #2;
        do_access(1'b0, 1'b0, 16'h0020, 16'h0000);
        check("post_reset_read", 32'(last_rdata), 32'h00EF);

        n0        = completions;
        min_low   = 99;
        cpu_we    = 1'b0;
        cpu_wide  = 1'b0;
        cpu_addr  = 16'h0010;
        cpu_req   = 1'b1;
        repeat (40) @(posedge clk);
        #2;
        cpu_req = 1'b0;
        wait_idle();
        check("b2b_count", 32'(completions - n0 >= 5), 32'd1);
        check("b2b_min_gap", 32'(min_low >= 1), 32'd1);
        check("b2b_rdata", 32'(last_rdata), 32'h005A);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
